// File: rtl/seg_scan_decoder.sv
// Recovers the digits shown on a multiplexed 7-segment display by sampling
// (seg, sel) once they have been stable, and publishes complete 4-digit frames.
module seg_scan_decoder #(
    parameter logic [15:0] STABLE_CYC = 16'd100
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  sel_in,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        code_err,
    output logic        sel_err
);

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] sel;
    } scan_t;

    localparam scan_t SCAN_RST = '{seg: 8'hFF, sel: 4'h0};

    scan_t            s1, s2, p;
    logic [15:0]      cnt;
    logic [3:0][3:0]  wrk, wrk_nxt;
    logic [3:0]       wblank, wblank_nxt;
    logic [3:0]       seen, seen_nxt;

    logic       changed, sample;
    logic       sel_idle, sel_multi;
    logic       dec_ok, dec_blank;
    logic [3:0] dec_val;

    assign changed   = (s2 != p);
    assign sample    = !changed && (cnt == STABLE_CYC - 16'd1);
    assign sel_idle  = (p.sel == 4'h0);
    assign sel_multi = ((p.sel & (p.sel - 4'd1)) != 4'h0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1  <= SCAN_RST;
            s2  <= SCAN_RST;
            p   <= SCAN_RST;
            cnt <= 16'd0;
        end else begin
            s1 <= '{seg: seg_in, sel: sel_in};
            s2 <= s1;
            p  <= s2;
            if (changed)
                cnt <= 16'd0;
            else if (cnt != STABLE_CYC)
                cnt <= cnt + 16'd1;
        end
    end

    // Exact 8-bit match; dp must be clear for every legal digit.
    always_comb begin
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        dec_val   = 4'h0;
        case (p.seg)
            8'hFC: dec_val = 4'h0;
            8'h60: dec_val = 4'h1;
            8'hDA: dec_val = 4'h2;
            8'hF2: dec_val = 4'h3;
            8'h66: dec_val = 4'h4;
            8'hB6: dec_val = 4'h5;
            8'hBE: dec_val = 4'h6;
            8'hE0: dec_val = 4'h7;
            8'hFE: dec_val = 4'h8;
            8'hF6: dec_val = 4'h9;
            8'hEE: dec_val = 4'hA;
            8'h3E: dec_val = 4'hB;
            8'h9C: dec_val = 4'hC;
            8'h7A: dec_val = 4'hD;
            8'h9E: dec_val = 4'hE;
            8'h8E: dec_val = 4'hF;
            8'hFF: dec_blank = 1'b1;
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        wrk_nxt    = wrk;
        wblank_nxt = wblank;
        seen_nxt   = seen;
        for (int i = 0; i < 4; i++) begin
            if (p.sel[i]) begin
                wrk_nxt[i]    = dec_val;
                wblank_nxt[i] = dec_blank;
                seen_nxt[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wrk         <= '0;
            wblank      <= 4'hF;
            seen        <= 4'h0;
            digits      <= 16'h0000;
            blank       <= 4'hF;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
            sel_err     <= 1'b0;
            if (sample && !sel_idle) begin
                if (sel_multi) begin
                    sel_err <= 1'b1;
                end else if (!dec_ok) begin
                    code_err <= 1'b1;
                end else begin
                    wrk    <= wrk_nxt;
                    wblank <= wblank_nxt;
                    // The completing sample goes straight into the published frame.
                    if (seen_nxt == 4'hF) begin
                        digits      <= wrk_nxt;
                        blank       <= wblank_nxt;
                        frame_valid <= 1'b1;
                        seen        <= 4'h0;
                    end else begin
                        seen <= seen_nxt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized + directed bench for seg_scan_decoder: a run-level reference model
// predicts each pulse (kind, edge, frame contents) into a scoreboard queue.
module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  seg_in = 8'hFF;
    logic [3:0]  sel_in = 4'h0;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_valid, code_err, sel_err;

    seg_scan_decoder #(.STABLE_CYC(16'(S))) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .seg_in(seg_in), .sel_in(sel_in),
        .digits(digits), .blank(blank), .frame_valid(frame_valid),
        .code_err(code_err), .sel_err(sel_err)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 frame, 1 code error, 2 sel error
        int          edge_no;
        logic [15:0] d;
        logic [3:0]  b;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    logic [7:0] seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    logic [7:0] multi_tab [7] = '{8'h3, 8'h5, 8'h6, 8'h9, 8'hA, 8'hC, 8'hF};

    // Reference model state: what the display has shown per slot so far.
    int   m_val [4];
    bit   m_blk [4];
    bit   m_seen [4];
    logic [7:0] last_seg = 8'hFF;
    logic [3:0] last_sel = 4'h0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_val[i] = 0; m_blk[i] = 1'b1; m_seen[i] = 1'b0;
        end
    endtask

    task automatic model_sample(input logic [7:0] seg, input logic [3:0] sel, input int ev);
        exp_t e;
        int slot, val;
        bit found, blk, all;
        e.d = '0; e.b = '0; e.edge_no = ev;
        if (sel == 4'h0) return;
        if ($countones(sel) != 1) begin
            e.kind = 2; q.push_back(e); return;
        end
        slot = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) slot = i;
        found = 1'b0; blk = 1'b0; val = 0;
        if (seg == 8'hFF) begin
            found = 1'b1; blk = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) if (seg_tab[i] == seg) begin found = 1'b1; val = i; end
        end
        if (!found) begin
            e.kind = 1; q.push_back(e); return;
        end
        m_val[slot] = val; m_blk[slot] = blk; m_seen[slot] = 1'b1;
        all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
        if (all) begin
            e.kind = 0;
            for (int i = 0; i < 4; i++) begin
                e.d[4*i +: 4] = 4'(m_val[i]);
                e.b[i] = m_blk[i];
                m_seen[i] = 1'b0;
            end
            q.push_back(e);
        end
    endtask

    // Hold one (seg, sel) value for len clock edges; it is sampled only if len > S.
    task automatic drive_run(input logic [7:0] seg, input logic [3:0] sel, input int len);
        int e;
        @(negedge sys_clk);
        seg_in = seg; sel_in = sel;
        last_seg = seg; last_sel = sel;
        e = cyc + 1;
        if (len >= S + 1) model_sample(seg, sel, e + S + 2);
        repeat (len - 1) @(negedge sys_clk);
    endtask

    task automatic do_reset();
        drive_run(8'hFF, 4'h0, 8);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        model_clear();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses; otherwise checks hold.
    logic [15:0] cur_d = 16'h0;
    logic [3:0]  cur_b = 4'hF;
    initial begin
        exp_t e;
        int np, k;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                cur_d = 16'h0; cur_b = 4'hF;
                chk(digits == 16'h0 && blank == 4'hF, "reset_outputs", {12'h0, blank, digits}, 32'h000F0000);
                chk({frame_valid, code_err, sel_err} == 3'b000, "reset_pulses",
                    {29'h0, frame_valid, code_err, sel_err}, 32'h0);
            end else begin
                np = int'(frame_valid) + int'(code_err) + int'(sel_err);
                if (np != 0) begin
                    chk(np == 1, "single_pulse", np, 1);
                    if (q.size() == 0) begin
                        chk(1'b0, "unexpected_pulse", {29'h0, frame_valid, code_err, sel_err}, 32'h0);
                    end else begin
                        e = q.pop_front();
                        k = frame_valid ? 0 : (code_err ? 1 : 2);
                        chk(k == e.kind, "pulse_kind", k, e.kind);
                        chk(cyc == e.edge_no, "pulse_edge", cyc, e.edge_no);
                        if (frame_valid) begin
                            chk(digits == e.d, "frame_digits", digits, e.d);
                            chk(blank == e.b, "frame_blank", blank, e.b);
                            cur_d = e.d; cur_b = e.b;
                        end
                    end
                end
                if (!frame_valid)
                    chk(digits == cur_d && blank == cur_b, "hold_outputs",
                        {12'h0, blank, digits}, {12'h0, cur_b, cur_d});
            end
        end
    end

    initial begin
        logic [7:0] sg;
        logic [3:0] sl;
        int r, len;
        model_clear();
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Plain frame, then one with a blank slot 3
        drive_run(8'hF2, 4'h1, 20); drive_run(8'hDA, 4'h2, 20);
        drive_run(8'hFC, 4'h4, 20); drive_run(8'hDA, 4'h8, 20);
        drive_run(8'hF2, 4'h1, 20); drive_run(8'hDA, 4'h2, 20);
        drive_run(8'hFC, 4'h4, 20); drive_run(8'hFF, 4'h8, 20);
        // Undecodable slot-1 pattern mid-frame
        drive_run(8'hF2, 4'h1, 20); drive_run(8'h45, 4'h2, 20);
        drive_run(8'hFC, 4'h4, 20); drive_run(8'hDA, 4'h8, 20);
        drive_run(8'hDA, 4'h2, 20);
        // Multi-bit select
        drive_run(8'hFC, 4'h3, 20);
        // Glitch of exactly S cycles is ignored, S+1 is sampled
        drive_run(8'hF2, 4'h1, 20); drive_run(8'h60, 4'h4, 4);
        drive_run(8'hDA, 4'h2, 20); drive_run(8'h60, 4'h4, 5);
        drive_run(8'hDA, 4'h8, 20);
        // Partial frame discarded by reset
        drive_run(8'hF2, 4'h1, 20); drive_run(8'hDA, 4'h2, 20);
        drive_run(8'hFC, 4'h4, 20);
        do_reset();
        drive_run(8'hDA, 4'h8, 20);

        for (int n = 0; n < 200; n++) begin
            if (n == 100) do_reset();
            do begin
                r = $urandom_range(0, 9);
                if (r == 0) sl = 4'h0;
                else if (r <= 7) sl = 4'(1 << (r % 4));
                else sl = multi_tab[$urandom_range(0, 6)][3:0];
                r = $urandom_range(0, 9);
                if (r <= 6) sg = seg_tab[$urandom_range(0, 15)];
                else if (r == 7) sg = 8'hFF;
                else sg = 8'($urandom_range(0, 255));
            end while (sg == last_seg && sl == last_sel);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 12);
            drive_run(sg, sl, len);
        end

        drive_run(8'hFF, 4'h0, 20);
        chk(q.size() == 0, "scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
